// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access codes, load/store predicates, data width.
package mem_pkg;

    localparam int DATA_W = 32;

    typedef logic [3:0] mem_op_t;

    localparam mem_op_t MEM_NONE = 4'd0;
    localparam mem_op_t MEM_LB   = 4'd1;
    localparam mem_op_t MEM_LBU  = 4'd2;
    localparam mem_op_t MEM_LH   = 4'd3;
    localparam mem_op_t MEM_LHU  = 4'd4;
    localparam mem_op_t MEM_LW   = 4'd5;
    localparam mem_op_t MEM_SB   = 4'd6;
    localparam mem_op_t MEM_SH   = 4'd7;
    localparam mem_op_t MEM_SW   = 4'd8;

    function automatic logic is_load(input mem_op_t op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM with per-byte write mask and read enable; no reset.
module data_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
        if (ren) rdata <= mem[addr];
    end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: byte/half/word load-store against data_ram plus the MEM/WB register.
// Optional misaligned-access detection is enabled by defining STAGE_MEM_ALIGN_CHECK_EN.
module stage_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] outAlu,
    input  logic [31:0] readRt,
    input  logic [3:0]  memOp,
    input  logic        regWriteIn,
    input  logic        memToRegIn,
    input  logic [4:0]  writeRegIn,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] memData,
    output logic [31:0] aluResult,
    output logic [4:0]  writeReg,
    output logic        regWrite,
    output logic        memToReg,
    output logic        misalign
);

    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        off;
    logic              bad;
    logic              wr_ok;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    mem_op_t           op_q;
    logic [1:0]        off_q;

    assign word_addr = outAlu[ADDR_W+1:2];
    assign off       = outAlu[1:0];

`ifdef STAGE_MEM_ALIGN_CHECK_EN
    logic mis_q;

    always_comb begin
        bad = 1'b0;
        case (memOp)
            MEM_LH, MEM_LHU, MEM_SH: bad = off[0];
            MEM_LW, MEM_SW:          bad = |off;
            default:                 bad = 1'b0;
        endcase
    end

    assign misalign = mis_q;
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif

    // reset is folded in so a store presented during reset never lands
    assign wr_ok = is_store(memOp) && !stall && !flush && !reset && !bad;

    always_comb begin
        be    = 4'b0000;
        wdata = readRt;
        case (memOp)
            MEM_SB: begin
                be    = 4'b0001 << off;
                wdata = {4{readRt[7:0]}};
            end
            MEM_SH: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{readRt[15:0]}};
            end
            MEM_SW:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!wr_ok) be = 4'b0000;
    end

    data_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (word_addr),
        .be    (be),
        .wdata (wdata),
        .ren   (!stall),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluResult <= '0;
            writeReg  <= '0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            op_q      <= MEM_NONE;
            off_q     <= '0;
        end else if (flush) begin
            aluResult <= '0;
            writeReg  <= '0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            op_q      <= MEM_NONE;
            off_q     <= '0;
        end else if (!stall) begin
            aluResult <= outAlu;
            writeReg  <= writeRegIn;
            regWrite  <= regWriteIn && !bad;
            memToReg  <= memToRegIn && !bad;
            // non-loads and rejected loads register as NONE so memData reads 0
            op_q      <= (is_load(memOp) && !bad) ? memOp : MEM_NONE;
            off_q     <= off;
        end
    end

`ifdef STAGE_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                mis_q <= 1'b0;
        else if (flush || stall)  mis_q <= 1'b0;
        else                      mis_q <= bad;
    end
`endif

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // halfword selection looks only at bit 1, which also forces alignment
    always_comb begin
        byte_v  = rdata[{off_q, 3'b000} +: 8];
        half_v  = off_q[1] ? rdata[31:16] : rdata[15:0];
        memData = '0;
        case (op_q)
            MEM_LB:  memData = {{24{byte_v[7]}}, byte_v};
            MEM_LBU: memData = {24'h0, byte_v};
            MEM_LH:  memData = {{16{half_v[15]}}, half_v};
            MEM_LHU: memData = {16'h0, half_v};
            MEM_LW:  memData = rdata;
            default: memData = '0;
        endcase
    end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the five-stage MIPS pipeline. Consumes the execute stage's ALU result (`outAlu`, used as the byte address) and store operand (`readRt`), and performs byte/half/word loads and stores against an internal synchronous data RAM. Registers the result, together with the write-back control, into the MEM/WB pipeline register that feeds the write-back mux.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address bits. The RAM holds 2^ADDR_W 32-bit words.

Ports:
- `clk` in 1: rising-edge clock; the block has this single clock.
- `reset` in 1: asynchronous, active-high reset.
- `outAlu` in 32: byte address, and the ALU result passed through to write-back.
- `readRt` in 32: store data.
- `memOp` in 4: access code.
  - 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW.
  - Codes 9–15 are treated as NONE.
- `regWriteIn` in 1, `memToRegIn` in 1, `writeRegIn` in 5: write-back control, carried through the stage.
- `stall` in 1: hold the stage.
- `flush` in 1: insert a bubble.
- `memData` out 32: extended load result.
- `aluResult` out 32: registered `outAlu`.
- `writeReg` out 5, `regWrite` out 1, `memToReg` out 1: registered write-back control.
- `misalign` out 1: one-cycle misaligned-access flag. Driven constant 0 when the feature is compiled out.

## Operation
- **Addressing:** word index is `outAlu[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_W bytes. Byte lanes are little-endian: lane k is bits [8k+7:8k].
- **Stores:** performed on the rising edge when `memOp` is SB/SH/SW, `stall`=0, `flush`=0 and `reset`=0.
  - SB writes lane `outAlu[1:0]` with `readRt[7:0]`.
  - SH writes lanes {0,1} or {2,3}, selected by `outAlu[1]`, with `readRt[15:0]`.
  - SW writes all four lanes.
  - Lanes not written keep their value.
- **Loads:** synchronous RAM read. The byte offset `outAlu[1:0]` and `memOp` are registered alongside the read, and extraction/extension happens on the registered word.
  - LB / LH: sign-extend to 32 bits.
  - LBU / LHU: zero-extend.
  - LW: whole word.
  - Any non-load op: `memData` = 0.
- **Stall:** all MEM/WB outputs hold. The RAM read enable is deasserted so `memData` holds. No store is performed.
- **Flush:** on the next edge, `regWrite`=0, `memToReg`=0, `writeReg`=0, `memData`=0 and `aluResult`=0. No store is performed.
- **Simultaneous events:** `flush` has priority over `stall`. Reset overrides both.
- **Reset:**
  - Reset value of every output is 0 (`memData`, `aluResult`, `writeReg`, `regWrite`, `memToReg`, `misalign`).
  - RAM contents are not cleared.
  - A store presented in the cycle reset is asserted is discarded.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- A store at edge N followed by a load of the same word at edge N+1 returns the new data (write-first across cycles). No same-cycle hazard exists, since one op is issued per cycle.
- Throughput is one access per cycle when not stalled.
- Consecutive stall cycles hold the outputs indefinitely. Operation resumes on the first edge with `stall`=0, using the inputs present at that edge.

## Configuration
- Macro `STAGE_MEM_ALIGN_CHECK_EN`.
- **Defined:**
  - LH/LHU/SH with `outAlu[0]`=1 is misaligned; LW/SW with `outAlu[1:0]`≠0 is misaligned.
  - On a misaligned access, the store is suppressed, and the registered `regWrite` and `memToReg` are 0.
  - `misalign` is 1 for exactly the cycle following the access. It is 0 during stall-hold after that cycle and on flush.
- **Undefined:**
  - Misaligned accesses are forced aligned: halfword uses `outAlu[1]` only, and word ignores `outAlu[1:0]`.
  - `misalign` is tied to 0.

## Structure
- Shared package `mem_pkg`: `memOp` encodings (MEM_NONE … MEM_SW), the helper predicates is_load/is_store, and `DATA_W`=32.
- One sub-module, `data_ram`: single-port synchronous RAM with a 4-bit byte-write mask and a read enable, depth 2^ADDR_W. It has no reset.
- Lane steering, extension, alignment check and the MEM/WB register live in `stage_mem`.

## Test plan
- **Word round-trip:** SW `readRt`=0xDEADBEEF at 0x10, then LW at 0x10 on the next cycle → `memData`=0xDEADBEEF one cycle later, `memToReg`=1.
- **Byte/half extension:** SW 0x80FF7F01 at 0x20.
  - LB at 0x23 → 0xFFFFFF80.
  - LBU at 0x23 → 0x00000080.
  - LH at 0x22 → 0xFFFF80FF.
  - LHU at 0x20 → 0x00007F01.
- **Partial store:** SW 0x11223344 at 0x30, SB 0xAA at 0x31, SH 0xBEEF at 0x32, then LW 0x30 → 0xBEEFAA44.
- **Stall/flush:**
  - LW issued with `stall`=1 for 3 cycles → outputs unchanged, and the RAM word is unchanged after an SW under stall.
  - `flush`=1 together with `stall`=1 → `regWrite`=0 and `memData`=0 on the next edge.
- **Wrap and reset:**
  - With `ADDR_W`=10, SW 0x5A5A5A5A at 0x1004, then LW 0x0004 → 0x5A5A5A5A.
  - Asserting `reset` mid-SW → all outputs 0 immediately, and the target word is unchanged.
- **Alignment (macro defined):** LW at 0x41 → `misalign`=1 for one cycle, `regWrite`=0. SH at 0x43 leaves memory unchanged. With the macro undefined, LW at 0x41 returns the word at 0x40.
